// File: rtl/sdrahb_cdc_wr_arbiter.sv
// sdrahb_cdc_wr_arbiter
// Round-robin write-port arbiter for one CDC_FIFO. A granted requester keeps
// the port until its LAST beat. Each accepted beat is tagged {id, last, data}
// and held in a single output stage that drives the FIFO write port.
//
// state  | meaning
// -------+----------------------------------------------------------------
// ARB    | no burst open; round-robin scan starting at rr_ptr
// BURST  | owner holds the port until it transfers a LAST beat (LOCKED=1)

module sdrahb_cdc_wr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 16,
  localparam int ID_W      = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ),
  localparam int WORD_W    = ID_W + 1 + DATA_WIDTH
) (
  input  logic                          CLK_WR,
  input  logic                          W_RST_N,
  input  logic                          TERMINATE,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ-1:0]            REQ_LAST,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic                          FIFO_RDY,
  output logic                          FIFO_WR_EN,
  output logic [WORD_W-1:0]             FIFO_DATA,
  output logic                          FIFO_TERM,
  output logic                          LOCKED
);

  typedef logic [ID_W-1:0] id_t;
  typedef enum logic {ST_ARB = 1'b0, ST_BURST = 1'b1} state_t;

  localparam id_t LAST_ID = id_t'(NUM_REQ - 1);

  state_t                  state;
  id_t                     rr_ptr;
  id_t                     owner;
  logic                    out_vld;
  logic [WORD_W-1:0]       out_word;
  logic                    fifo_term;

  logic [NUM_REQ-1:0]      grant;
  logic                    slot_free;
  logic                    xfer;
  id_t                     xfer_id;
  logic                    xfer_last;
  logic [DATA_WIDTH-1:0]   xfer_data;

  // Explicit wrap so non-power-of-two requester counts never point past the end.
  function automatic id_t wrap_inc(input id_t v);
    return (v == LAST_ID) ? '0 : id_t'(v + 1'b1);
  endfunction

  // Grant: burst owner when locked, else first valid requester from rr_ptr onward.
  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    idx   = 0;
    found = 1'b0;
    if (state == ST_BURST) begin
      grant[owner] = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && REQ_VALID[id_t'(idx)]) begin
          grant[id_t'(idx)] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  // Ready is withheld while the stage is stuck or an abort is in flight;
  // the reset term keeps REQ_READY low for the whole time reset is asserted.
  assign slot_free = !out_vld || FIFO_RDY;
  assign REQ_READY = (slot_free && !TERMINATE && !fifo_term && W_RST_N) ? grant : '0;

  // Select the beat being transferred this cycle (grant is one-hot or zero).
  always_comb begin
    xfer      = 1'b0;
    xfer_id   = '0;
    xfer_last = 1'b0;
    xfer_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (REQ_VALID[i] && REQ_READY[i]) begin
        xfer      = 1'b1;
        xfer_id   = id_t'(i);
        xfer_last = REQ_LAST[i];
        xfer_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arbiter FSM, round-robin pointer and the one-entry output stage.
  always_ff @(posedge CLK_WR or negedge W_RST_N) begin
    if (!W_RST_N) begin
      state     <= ST_ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      out_vld   <= 1'b0;
      out_word  <= '0;
      fifo_term <= 1'b0;
    end else begin
      fifo_term <= TERMINATE;
      if (TERMINATE) begin
        out_vld  <= 1'b0;
        out_word <= '0;
        state    <= ST_ARB;
        rr_ptr   <= '0;
      end else begin
        if (xfer) begin
          out_vld  <= 1'b1;
          out_word <= {xfer_id, xfer_last, xfer_data};
        end else if (FIFO_RDY) begin
          out_vld  <= 1'b0;
        end
        if (xfer) begin
          if (xfer_last) begin
            rr_ptr <= wrap_inc(xfer_id);
            state  <= ST_ARB;
          end else begin
            owner  <= xfer_id;
            state  <= ST_BURST;
          end
        end
      end
    end
  end

  assign FIFO_WR_EN = out_vld;
  assign FIFO_DATA  = out_word;
  assign FIFO_TERM  = fifo_term;
  assign LOCKED     = (state == ST_BURST);

endmodule

// File: tb/tb_sdrahb_cdc_wr_arbiter.sv
// Bench for sdrahb_cdc_wr_arbiter: directed vector table, hand sequences for
// NUM_REQ=3 wrap and async reset, then randomized traffic against a model.

module tb_sdrahb_cdc_wr_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        term;
  logic [1:0]  vld, last;
  logic [31:0] data;
  logic [1:0]  ready;
  logic        rdy;
  logic        wen;
  logic [17:0] fdata;
  logic        fterm;
  logic        locked;

  logic        term3;
  logic [2:0]  vld3, last3;
  logic [47:0] data3;
  logic [2:0]  ready3;
  logic        rdy3;
  logic        wen3;
  logic [18:0] fdata3;
  logic        fterm3;
  logic        locked3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sdrahb_cdc_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(16)) dut (
    .CLK_WR(clk), .W_RST_N(rst_n), .TERMINATE(term),
    .REQ_VALID(vld), .REQ_LAST(last), .REQ_DATA(data), .REQ_READY(ready),
    .FIFO_RDY(rdy), .FIFO_WR_EN(wen), .FIFO_DATA(fdata),
    .FIFO_TERM(fterm), .LOCKED(locked));

  sdrahb_cdc_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(16)) dut3 (
    .CLK_WR(clk), .W_RST_N(rst_n), .TERMINATE(term3),
    .REQ_VALID(vld3), .REQ_LAST(last3), .REQ_DATA(data3), .REQ_READY(ready3),
    .FIFO_RDY(rdy3), .FIFO_WR_EN(wen3), .FIFO_DATA(fdata3),
    .FIFO_TERM(fterm3), .LOCKED(locked3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [1:0]  vld;
    logic [1:0]  last;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        rdy;
    logic        term;
    logic [1:0]  e_ready;
    logic        e_wen;
    logic [17:0] e_data;
    logic        e_lock;
    logic        e_term;
  } vec_t;

  vec_t tbl [21];

  // Reference model: arbitration expressed with plain integers and modulo.
  int          m_rr, m_owner;
  bit          m_lock, m_vld, m_term;
  logic [17:0] m_word;

  task automatic model_reset();
    m_rr = 0; m_owner = 0; m_lock = 0; m_vld = 0; m_term = 0; m_word = '0;
  endtask

  task automatic model_ready(output logic [1:0] r);
    bit free;
    int j;
    free = !m_vld || rdy;
    r = '0;
    if (term || m_term || !free) return;
    if (m_lock) begin
      r[m_owner] = 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        j = (m_rr + k) % 2;
        if (vld[j]) begin
          r[j] = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic model_step(input logic [1:0] r);
    int xi;
    xi = -1;
    for (int i = 0; i < 2; i++) if (vld[i] && r[i]) xi = i;
    if (term) begin
      m_vld = 0; m_rr = 0; m_lock = 0; m_term = 1;
    end else begin
      m_term = 0;
      if (xi >= 0) begin
        m_vld  = 1;
        m_word = {(xi == 1), last[xi], (xi == 1) ? data[31:16] : data[15:0]};
        if (last[xi]) begin
          m_rr = (xi + 1) % 2;
          m_lock = 0;
        end else begin
          m_lock = 1;
          m_owner = xi;
        end
      end else if (rdy) begin
        m_vld = 0;
      end
    end
  endtask

  initial begin
    logic [1:0] er;

    //            vld    last   d0        d1        rdy term  e_rdy e_wen e_data     lock term
    tbl[0]  = '{2'b11, 2'b11, 16'h0A00, 16'h0B00, H, L, 2'b01, L, 18'h00000, L, L};
    tbl[1]  = '{2'b11, 2'b11, 16'h0A01, 16'h0B01, H, L, 2'b10, H, 18'h10A00, L, L};
    tbl[2]  = '{2'b11, 2'b11, 16'h0A02, 16'h0B02, H, L, 2'b01, H, 18'h30B01, L, L};
    tbl[3]  = '{2'b11, 2'b11, 16'h0A03, 16'h0B03, H, L, 2'b10, H, 18'h10A02, L, L};
    tbl[4]  = '{2'b11, 2'b00, 16'h0C01, 16'h0D00, H, L, 2'b01, H, 18'h30B03, L, L};
    tbl[5]  = '{2'b11, 2'b00, 16'h0C02, 16'h0D00, H, L, 2'b01, H, 18'h00C01, H, L};
    tbl[6]  = '{2'b11, 2'b00, 16'h0C03, 16'h0D00, H, L, 2'b01, H, 18'h00C02, H, L};
    tbl[7]  = '{2'b11, 2'b01, 16'h0C04, 16'h0D00, H, L, 2'b01, H, 18'h00C03, H, L};
    tbl[8]  = '{2'b10, 2'b10, 16'h0000, 16'h0D05, H, L, 2'b10, H, 18'h10C04, L, L};
    tbl[9]  = '{2'b01, 2'b01, 16'h1234, 16'h0000, H, L, 2'b01, H, 18'h30D05, L, L};
    tbl[10] = '{2'b11, 2'b11, 16'h0000, 16'h0000, L, L, 2'b00, H, 18'h11234, L, L};
    tbl[11] = '{2'b11, 2'b11, 16'h0000, 16'h0000, L, L, 2'b00, H, 18'h11234, L, L};
    tbl[12] = '{2'b11, 2'b11, 16'h0000, 16'h0000, L, L, 2'b00, H, 18'h11234, L, L};
    tbl[13] = '{2'b00, 2'b00, 16'h0000, 16'h0000, H, L, 2'b00, H, 18'h11234, L, L};
    tbl[14] = '{2'b00, 2'b00, 16'h0000, 16'h0000, H, L, 2'b00, L, 18'h00000, L, L};
    tbl[15] = '{2'b10, 2'b00, 16'h0000, 16'h0E01, H, L, 2'b10, L, 18'h00000, L, L};
    tbl[16] = '{2'b10, 2'b00, 16'h0000, 16'h0E02, H, L, 2'b10, H, 18'h20E01, H, L};
    tbl[17] = '{2'b11, 2'b00, 16'h0F00, 16'h0E03, H, H, 2'b00, H, 18'h20E02, H, L};
    tbl[18] = '{2'b11, 2'b11, 16'h0F00, 16'h0E04, H, L, 2'b00, L, 18'h00000, L, H};
    tbl[19] = '{2'b11, 2'b11, 16'h0F01, 16'h0E05, H, L, 2'b01, L, 18'h00000, L, L};
    tbl[20] = '{2'b00, 2'b00, 16'h0000, 16'h0000, H, L, 2'b00, H, 18'h10F01, L, L};

    // reset with requests pending
    rst_n = 1'b0; term = 1'b0; vld = 2'b11; last = 2'b11; data = '0; rdy = 1'b1;
    term3 = 1'b0; vld3 = '0; last3 = '0; data3 = '0; rdy3 = 1'b1;
    @(negedge clk); #1;
    chk("rst_ready",  32'(ready),  32'd0);
    chk("rst_wen",    32'(wen),    32'd0);
    chk("rst_data",   32'(fdata),  32'd0);
    chk("rst_lock",   32'(locked), 32'd0);
    chk("rst_term",   32'(fterm),  32'd0);
    chk("rst_ready3", 32'(ready3), 32'd0);
    @(negedge clk);
    vld = 2'b00;
    rst_n = 1'b1;

    // directed vectors
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      vld = tbl[i].vld; last = tbl[i].last; data = {tbl[i].d1, tbl[i].d0};
      rdy = tbl[i].rdy; term = tbl[i].term;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(ready), 32'(tbl[i].e_ready));
      chk($sformatf("vec%0d_wen", i),   32'(wen),   32'(tbl[i].e_wen));
      if (tbl[i].e_wen)
        chk($sformatf("vec%0d_data", i), 32'(fdata), 32'(tbl[i].e_data));
      chk($sformatf("vec%0d_lock", i),  32'(locked), 32'(tbl[i].e_lock));
      chk($sformatf("vec%0d_fterm", i), 32'(fterm),  32'(tbl[i].e_term));
    end

    // NUM_REQ=3: req2 twice with LAST wraps pointer to 0, then req0 beats req1
    @(negedge clk);
    vld3 = 3'b100; last3 = 3'b100; data3 = {16'h5501, 16'h0, 16'h0};
    #1; chk("wrap_b1_ready", 32'(ready3), 32'h4);
    @(negedge clk);
    data3 = {16'h5502, 16'h0, 16'h0};
    #1; chk("wrap_b2_ready", 32'(ready3), 32'h4);
    chk("wrap_b1_data", 32'(fdata3), 32'h55501);
    @(negedge clk);
    vld3 = 3'b011; last3 = 3'b011; data3 = {16'h0, 16'h6601, 16'h6600};
    #1; chk("wrap_tie_ready", 32'(ready3), 32'h1);
    chk("wrap_b2_data", 32'(fdata3), 32'h55502);
    @(negedge clk);
    vld3 = 3'b000;
    #1; chk("wrap_tie_data", 32'(fdata3), 32'h16600);
    chk("wrap_tie_wen", 32'(wen3), 32'h1);

    // async reset mid-burst
    @(negedge clk);
    vld = 2'b01; last = 2'b00; data = {16'h0, 16'h7001}; rdy = 1'b1; term = 1'b0;
    @(negedge clk);
    data = {16'h0, 16'h7002};
    #1; chk("burst_lock", 32'(locked), 32'd1);
    chk("burst_wen", 32'(wen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wen",   32'(wen),    32'd0);
    chk("arst_data",  32'(fdata),  32'd0);
    chk("arst_lock",  32'(locked), 32'd0);
    chk("arst_term",  32'(fterm),  32'd0);
    chk("arst_ready", 32'(ready),  32'd0);
    @(negedge clk);
    vld = 2'b00;
    rst_n = 1'b1;
    model_reset();

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      vld  = 2'($urandom_range(0, 3));
      last = 2'($urandom_range(0, 3));
      data = $urandom;
      rdy  = ($urandom_range(0, 3) != 0);
      term = ($urandom_range(0, 31) == 0);
      #1;
      model_ready(er);
      chk("rnd_ready", 32'(ready),  32'(er));
      chk("rnd_wen",   32'(wen),    32'(m_vld));
      if (m_vld) chk("rnd_data", 32'(fdata), 32'(m_word));
      chk("rnd_lock",  32'(locked), 32'(m_lock));
      chk("rnd_fterm", 32'(fterm),  32'(m_term));
      model_step(er);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
